battlefront_calc: RTL and testbench

BATTLEFRONT_CALC -- requirements
Module: battlefront_calc

---
 rtl/battlefront_calc.sv | 162 ++++++++++++++++
 tb/tb_battlefront_calc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/battlefront_calc.sv
// battlefront_calc: per-tick battle resolver. Every TICK_LEN cycles it scans
// the four player and four enemy slots, one slot pair per cycle. It then
// publishes the two front positions and the contact flag. After that it
// issues a damage strobe followed by a move strobe.
module battlefront_calc #(
  parameter int unsigned TICK_LEN = 2_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [35:0] playerPos,
  input  logic [7:0]  playerType,
  input  logic [31:0] playerDmg,
  input  logic [35:0] enemyPos,
  input  logic [7:0]  enemyType,
  input  logic [31:0] enemyDmg,
  output logic [8:0]  enemyFront,
  output logic [8:0]  playerFront,
  output logic [7:0]  playerDamageIn,
  output logic [7:0]  enemyDamageIn,
  output logic        damageSCEN,
  output logic        moveSCEN,
  output logic        contact
);

  localparam int unsigned CW = $clog2(TICK_LEN);

  typedef enum logic [1:0] {IDLE, SCAN, DAMAGE, MOVE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] tick_cnt;
  logic          tick_wrap;
  logic [1:0]    idx;

  logic [8:0]    e_max, p_min;
  logic [7:0]    e_sum, p_sum;
  logic          e_any, p_any;

  logic [8:0]    e_max_n, p_min_n;
  logic [7:0]    e_sum_n, p_sum_n;
  logic          e_any_n, p_any_n;
  logic [8:0]    e_tmp, p_tmp;

  logic [8:0]    epos [4];
  logic [8:0]    ppos [4];
  logic [7:0]    edmg [4];
  logic [7:0]    pdmg [4];
  logic          ealive [4];
  logic          palive [4];

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    assign epos[g]   = enemyPos[9*g +: 9];
    assign ppos[g]   = playerPos[9*g +: 9];
    assign edmg[g]   = enemyDmg[8*g +: 8];
    assign pdmg[g]   = playerDmg[8*g +: 8];
    assign ealive[g] = |enemyType[2*g +: 2];
    assign palive[g] = |playerType[2*g +: 2];
  end

  assign tick_wrap = (tick_cnt == CW'(TICK_LEN - 1));

  // Free-running tick counter, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          tick_cnt <= '0;
    else if (tick_wrap) tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + CW'(1);
  end

  // Fold the slot currently being scanned into the running results.
  always_comb begin
    e_max_n = e_max;
    p_min_n = p_min;
    e_any_n = e_any;
    p_any_n = p_any;
    e_tmp   = {1'b0, e_sum} + {1'b0, edmg[idx]};
    p_tmp   = {1'b0, p_sum} + {1'b0, pdmg[idx]};
    e_sum_n = e_sum;
    p_sum_n = p_sum;
    if (ealive[idx]) begin
      e_any_n = 1'b1;
      if (epos[idx] > e_max) e_max_n = epos[idx];
      e_sum_n = e_tmp[8] ? 8'hFF : e_tmp[7:0];
    end
    if (palive[idx]) begin
      p_any_n = 1'b1;
      if (ppos[idx] < p_min) p_min_n = ppos[idx];
      p_sum_n = p_tmp[8] ? 8'hFF : p_tmp[7:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and strobe outputs; a tick wrap outside IDLE is dropped.
  always_comb begin
    state_next     = state;
    damageSCEN     = 1'b0;
    moveSCEN       = 1'b0;
    playerDamageIn = '0;
    enemyDamageIn  = '0;
    unique case (state)
      IDLE:   if (tick_wrap) state_next = SCAN;
      SCAN:   if (idx == 2'd3) state_next = DAMAGE;
      DAMAGE: begin
        state_next     = MOVE;
        damageSCEN     = 1'b1;
        playerDamageIn = contact ? e_sum : '0;
        enemyDamageIn  = contact ? p_sum : '0;
      end
      MOVE: begin
        state_next = IDLE;
        moveSCEN   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Scan accumulators; the sums stay held through DAMAGE for the damage outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      e_max <= '0;
      p_min <= '1;
      e_sum <= '0;
      p_sum <= '0;
      e_any <= 1'b0;
      p_any <= 1'b0;
    end else if (state == IDLE && tick_wrap) begin
      idx   <= '0;
      e_max <= '0;
      p_min <= '1;
      e_sum <= '0;
      p_sum <= '0;
      e_any <= 1'b0;
      p_any <= 1'b0;
    end else if (state == SCAN) begin
      idx   <= idx + 2'd1;
      e_max <= e_max_n;
      p_min <= p_min_n;
      e_sum <= e_sum_n;
      p_sum <= p_sum_n;
      e_any <= e_any_n;
      p_any <= p_any_n;
    end
  end

  // Publish the fronts and contact on entry to DAMAGE, including the last slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enemyFront  <= '0;
      playerFront <= '1;
      contact     <= 1'b0;
    end else if (state == SCAN && idx == 2'd3) begin
      enemyFront  <= e_max_n;
      playerFront <= p_min_n;
      contact     <= e_any_n && p_any_n && (e_max_n >= p_min_n);
    end
  end

endmodule

// File: tb/tb_battlefront_calc.sv
// tb_battlefront_calc: drives directed and random battle layouts. It checks
// every cycle against a slot-level model of one tick.
module tb_battlefront_calc;

  localparam int TL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] playerPos, enemyPos;
  logic [7:0]  playerType, enemyType;
  logic [31:0] playerDmg, enemyDmg;
  logic [8:0]  enemyFront, playerFront;
  logic [7:0]  playerDamageIn, enemyDamageIn;
  logic        damageSCEN, moveSCEN, contact;

  battlefront_calc #(.TICK_LEN(TL)) dut (
    .clk(clk), .reset(reset),
    .playerPos(playerPos), .playerType(playerType), .playerDmg(playerDmg),
    .enemyPos(enemyPos), .enemyType(enemyType), .enemyDmg(enemyDmg),
    .enemyFront(enemyFront), .playerFront(playerFront),
    .playerDamageIn(playerDamageIn), .enemyDamageIn(enemyDamageIn),
    .damageSCEN(damageSCEN), .moveSCEN(moveSCEN), .contact(contact)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int ppos [4], ptyp [4], pdmg [4];
  int epos [4], etyp [4], edmg [4];

  // model results for the layout currently applied, and the published values
  int pend_ef, pend_pf, pend_pd, pend_ed;
  bit pend_c;
  int cur_ef = 0, cur_pf = 511, cur_pd = 0, cur_ed = 0;
  bit cur_c = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Drive the slot arrays onto the ports and compute what one tick should report.
  task automatic apply();
    int es, ps;
    bit ea, pa;
    pend_ef = 0; pend_pf = 511; es = 0; ps = 0; ea = 0; pa = 0;
    for (int i = 0; i < 4; i++) begin
      playerPos[9*i +: 9] = 9'(ppos[i]);
      playerType[2*i +: 2] = 2'(ptyp[i]);
      playerDmg[8*i +: 8] = 8'(pdmg[i]);
      enemyPos[9*i +: 9] = 9'(epos[i]);
      enemyType[2*i +: 2] = 2'(etyp[i]);
      enemyDmg[8*i +: 8] = 8'(edmg[i]);
      if (etyp[i] != 0) begin
        ea = 1; es += edmg[i];
        if (epos[i] > pend_ef) pend_ef = epos[i];
      end
      if (ptyp[i] != 0) begin
        pa = 1; ps += pdmg[i];
        if (ppos[i] < pend_pf) pend_pf = ppos[i];
      end
    end
    pend_c  = ea && pa && (pend_ef >= pend_pf);
    pend_pd = pend_c ? ((es > 255) ? 255 : es) : 0;
    pend_ed = pend_c ? ((ps > 255) ? 255 : ps) : 0;
  endtask

  task automatic all_dead();
    for (int i = 0; i < 4; i++) begin
      ppos[i] = 17 * i + 3; ptyp[i] = 0; pdmg[i] = 9;
      epos[i] = 500 - i;    etyp[i] = 0; edmg[i] = 9;
    end
  endtask

  function automatic int phase();
    return (n >= TL) ? (n - TL) % TL : -1;
  endfunction

  // One clock: advance, then check every output at the falling edge.
  task automatic cycle();
    @(posedge clk);
    n++;
    @(negedge clk);
    if (phase() == 4) begin
      cur_ef = pend_ef; cur_pf = pend_pf; cur_c = pend_c;
      cur_pd = pend_pd; cur_ed = pend_ed;
    end
    chk("damageSCEN", int'(damageSCEN), int'(phase() == 4));
    chk("moveSCEN", int'(moveSCEN), int'(phase() == 5));
    chk("playerDamageIn", int'(playerDamageIn), (phase() == 4) ? cur_pd : 0);
    chk("enemyDamageIn", int'(enemyDamageIn), (phase() == 4) ? cur_ed : 0);
    chk("enemyFront", int'(enemyFront), cur_ef);
    chk("playerFront", int'(playerFront), cur_pf);
    chk("contact", int'(contact), int'(cur_c));
  endtask

  task automatic run_to_move();
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (phase() != 5 && k < 40);
    chk("move_within_budget", int'(phase() == 5), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_enemyFront"}, int'(enemyFront), 0);
    chk({tag, "_playerFront"}, int'(playerFront), 511);
    chk({tag, "_pdmg"}, int'(playerDamageIn), 0);
    chk({tag, "_edmg"}, int'(enemyDamageIn), 0);
    chk({tag, "_dSCEN"}, int'(damageSCEN), 0);
    chk({tag, "_mSCEN"}, int'(moveSCEN), 0);
    chk({tag, "_contact"}, int'(contact), 0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    all_dead();
    apply();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    n = 0;

    // all slots dead, two ticks
    run_to_move();
    run_to_move();

    // players at 300, enemies at 100 and 150: no contact
    all_dead();
    for (int i = 0; i < 4; i++) begin ppos[i] = 300; ptyp[i] = 1; pdmg[i] = 0; end
    epos[0] = 100; etyp[0] = 2; edmg[0] = 'h40;
    epos[1] = 150; etyp[1] = 2; edmg[1] = 'h40;
    apply();
    run_to_move();

    // equal fronts at 150: contact, both damages delivered
    all_dead();
    ppos[0] = 150; ptyp[0] = 1; pdmg[0] = 'h20;
    epos[0] = 150; etyp[0] = 3; edmg[0] = 'h40;
    apply();
    run_to_move();

    // four enemies at 0x80 each: damage saturates
    all_dead();
    for (int i = 0; i < 4; i++) begin epos[i] = 200 + i; etyp[i] = 1 + i % 3; edmg[i] = 'h80; end
    ppos[2] = 100; ptyp[2] = 2; pdmg[2] = 'h11;
    apply();
    run_to_move();

    // dead enemy at 400 excluded from front and damage
    all_dead();
    epos[2] = 400; etyp[2] = 0; edmg[2] = 'hFF;
    epos[0] = 120; etyp[0] = 1; edmg[0] = 5;
    ppos[3] = 110; ptyp[3] = 3; pdmg[3] = 7;
    apply();
    run_to_move();

    // random layouts
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) begin
        ppos[i] = int'($urandom_range(511, 0));
        ptyp[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(3, 1));
        pdmg[i] = int'($urandom_range(255, 0));
        epos[i] = int'($urandom_range(511, 0));
        etyp[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(3, 1));
        edmg[i] = int'($urandom_range(255, 0));
      end
      apply();
      run_to_move();
    end

    // contact layout published, then reset during the second scan cycle
    all_dead();
    ppos[1] = 150; ptyp[1] = 1; pdmg[1] = 'h20;
    epos[3] = 160; etyp[3] = 2; edmg[3] = 'h40;
    apply();
    run_to_move();
    k = 0;
    do begin
      cycle();
      k++;
    end while (phase() != 1 && k < 40);
    chk("scan2_reached", int'(phase() == 1), 1);
    reset = 1'b1;
    #1;
    check_reset_values("midscan");
    cur_ef = 0; cur_pf = 511; cur_c = 0; cur_pd = 0; cur_ed = 0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    run_to_move();
    run_to_move();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout n=%0d observed=running expected=finished", n);
    $fatal(1, "timeout");
  end

endmodule
